// File: rtl/pendulum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pendulum_pkg
// Purpose  : Shared constants and types for the pendulum/stepper datapath.
//            STEPS_PER_REV is shared with the gravity ROM addressing.
// Revision : 1.0 - initial release
// ============================================================================
package pendulum_pkg;

    // Microsteps in one full revolution of the motor shaft.
    localparam int STEPS_PER_REV = 3200;

    // Level of the dir line for each direction of travel.
    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    // Step pulse tracking states.
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pulse_state_t;

endpackage : pendulum_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : 2-flop synchronizer for an asynchronous line, plus a
//            previous-value flop giving single-cycle rise/fall strobes.
// Ports    : clock, reset - system clock, synchronous active-high reset
//            refill       - high while the synchronizer refills after reset;
//                           edges are suppressed and the previous-value flop
//                           tracks the value about to reach the output
//            din          - asynchronous input line
//            level        - synchronized level
//            rise, fall   - one-cycle edge strobes of the synchronized level
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic refill,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // While refilling, preload prev with the value that sync2 is about
            // to take, so a line already high at reset release gives no edge.
            r_prev  <= refill ? r_sync1 : r_sync2;
        end
    end

    assign level = r_sync2;
    assign rise  =  r_sync2 & ~r_prev & ~refill;
    assign fall  = ~r_sync2 &  r_prev & ~refill;

endmodule : sync_edge
`default_nettype wire

// File: rtl/step_dir_decoder.sv
`default_nettype none
// ============================================================================
// Module   : step_dir_decoder
// Purpose  : Receive-side step/dir decoder. Counts step rising edges into a
//            wrapped microstep position and a per-window signed delta, and
//            flags short step pulses and late dir changes.
// Ports    : clock, reset  - system clock, synchronous active-high reset
//            step, dir     - asynchronous step/dir lines (dir 1 = +1 step)
//            window_sync   - closes the counting window (one-cycle pulse)
//            zero_pos      - forces position to 0
//            err_clear     - clears the sticky error flags
//            position      - 0..stepsPerRev-1
//            delta_steps   - signed net steps of the last closed window
//            delta_valid   - one-cycle pulse when delta_steps updates
//            err_pulse     - sticky: step high time below minHighTime
//            err_dir       - sticky: dir stable fewer than dirSetup clocks
// Revision : 1.0 - initial release
// ============================================================================
module step_dir_decoder
    import pendulum_pkg::*;
#(
    parameter int stepsPerRev = STEPS_PER_REV,
    parameter int minHighTime = 50,
    parameter int dirSetup    = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step,
    input  logic               dir,
    input  logic               window_sync,
    input  logic               zero_pos,
    input  logic               err_clear,
    output logic [15:0]        position,
    output logic signed [15:0] delta_steps,
    output logic               delta_valid,
    output logic               err_pulse,
    output logic               err_dir
);

    localparam logic [15:0]        c_LAST_POS  = 16'(stepsPerRev - 1);
    localparam logic [15:0]        c_MIN_HIGH  = 16'(minHighTime);
    localparam logic [15:0]        c_DIR_SETUP = 16'(dirSetup);
    localparam logic signed [15:0] c_WIN_MAX   = 16'sh7FFF;
    localparam logic signed [15:0] c_WIN_MIN   = 16'sh8000;

    logic [1:0]         r_refill_cnt;
    pulse_state_t       r_state;
    pulse_state_t       w_state_next;
    logic [15:0]        r_high_cnt;
    logic [15:0]        w_high_cnt_next;
    logic [15:0]        r_dir_stable;
    logic [15:0]        r_position;
    logic signed [15:0] r_window;
    logic signed [15:0] w_window_next;
    logic signed [15:0] r_delta;
    logic               r_delta_valid;
    logic               r_err_pulse;
    logic               r_err_dir;

    logic w_refill;
    logic w_step_level, w_step_rise, w_step_fall;
    logic w_dir_level, w_dir_rise, w_dir_fall;
    logic w_pulse_err;
    logic w_dir_err;
    logic [15:0] w_pos_inc;
    logic [15:0] w_pos_dec;

    // Edge detection is held off for two cycles after reset while the
    // synchronizers refill from their cleared state.
    assign w_refill = (r_refill_cnt != 2'd0);

    sync_edge u_step_sync (
        .clock  (clock),
        .reset  (reset),
        .refill (w_refill),
        .din    (step),
        .level  (w_step_level),
        .rise   (w_step_rise),
        .fall   (w_step_fall)
    );

    sync_edge u_dir_sync (
        .clock  (clock),
        .reset  (reset),
        .refill (w_refill),
        .din    (dir),
        .level  (w_dir_level),
        .rise   (w_dir_rise),
        .fall   (w_dir_fall)
    );

    // Pulse FSM: measures step high time between rise and fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= LOW;
            r_high_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_high_cnt <= w_high_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_high_cnt_next = r_high_cnt;
        w_pulse_err     = 1'b0;
        case (r_state)
            LOW: begin
                if (w_step_rise) begin
                    w_high_cnt_next = 16'd0;
                    w_state_next    = HIGH;
                end
            end
            HIGH: begin
                if (w_step_fall) begin
                    w_pulse_err  = (r_high_cnt < c_MIN_HIGH);
                    w_state_next = LOW;
                end else if (w_step_level && (r_high_cnt < c_MIN_HIGH)) begin
                    w_high_cnt_next = r_high_cnt + 16'd1;
                end
            end
            default: w_state_next = LOW;
        endcase
    end

    // Position and window arithmetic for a step in either direction.
    assign w_pos_inc = (r_position == c_LAST_POS) ? 16'd0 : r_position + 16'd1;
    assign w_pos_dec = (r_position == 16'd0) ? c_LAST_POS : r_position - 16'd1;
    assign w_dir_err = w_step_rise && (r_dir_stable < c_DIR_SETUP);

    always_comb begin
        w_window_next = r_window;
        if (w_step_rise) begin
            if (w_dir_level == DIR_POS) begin
                if (r_window != c_WIN_MAX) w_window_next = r_window + 16'sd1;
            end else begin
                if (r_window != c_WIN_MIN) w_window_next = r_window - 16'sd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_refill_cnt  <= 2'd2;
            r_dir_stable  <= 16'd0;
            r_position    <= 16'd0;
            r_window      <= 16'sd0;
            r_delta       <= 16'sd0;
            r_delta_valid <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_dir     <= 1'b0;
        end else begin
            if (w_refill) r_refill_cnt <= r_refill_cnt - 2'd1;

            if (w_dir_rise || w_dir_fall)    r_dir_stable <= 16'd0;
            else if (r_dir_stable < c_DIR_SETUP) r_dir_stable <= r_dir_stable + 16'd1;

            if (zero_pos)
                r_position <= 16'd0;
            else if (w_step_rise)
                r_position <= (w_dir_level == DIR_POS) ? w_pos_inc : w_pos_dec;

            // A step in the closing cycle belongs to the window being closed.
            if (window_sync) begin
                r_delta  <= w_window_next;
                r_window <= 16'sd0;
            end else begin
                r_window <= w_window_next;
            end
            r_delta_valid <= window_sync;

            // A new error event takes priority over a clear.
            r_err_pulse <= w_pulse_err | (r_err_pulse & ~err_clear);
            r_err_dir   <= w_dir_err   | (r_err_dir   & ~err_clear);
        end
    end

    assign position    = r_position;
    assign delta_steps = r_delta;
    assign delta_valid = r_delta_valid;
    assign err_pulse   = r_err_pulse;
    assign err_dir     = r_err_dir;

endmodule : step_dir_decoder
`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_dir_decoder
// Purpose  : Self-checking bench for step_dir_decoder. A behavioural model
//            tracks position, window count and error flags per driven pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_dir_decoder;

    localparam int c_STEPS     = 3200;
    localparam int c_MIN_HIGH  = 50;
    localparam int c_DIR_SETUP = 50;

    logic               clock = 1'b0;
    logic               reset;
    logic               step;
    logic               dir;
    logic               window_sync;
    logic               zero_pos;
    logic               err_clear;
    logic [15:0]        position;
    logic signed [15:0] delta_steps;
    logic               delta_valid;
    logic               err_pulse;
    logic               err_dir;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    int m_pos  = 0;
    int m_win  = 0;
    int m_errp = 0;
    int m_errd = 0;
    int m_gap  = 0;   // clocks since dir last changed (or since reset)

    always #5 clock = ~clock;

    step_dir_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .step        (step),
        .dir         (dir),
        .window_sync (window_sync),
        .zero_pos    (zero_pos),
        .err_clear   (err_clear),
        .position    (position),
        .delta_steps (delta_steps),
        .delta_valid (delta_valid),
        .err_pulse   (err_pulse),
        .err_dir     (err_dir)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            m_gap++;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".position"}, int'(position), m_pos);
        check({tag, ".err_pulse"}, int'(err_pulse), m_errp);
        check({tag, ".err_dir"}, int'(err_dir), m_errd);
    endtask

    task automatic set_dir(input logic d);
        if (d !== dir) begin
            dir   = d;
            m_gap = 0;
        end
    endtask

    // Model of one counted step at the current dir.
    task automatic model_rise();
        if (m_gap < c_DIR_SETUP) m_errd = 1;
        m_pos = dir ? (m_pos + 1) % c_STEPS : (m_pos + c_STEPS - 1) % c_STEPS;
        m_win = m_win + (dir ? 1 : -1);
        if (m_win > 32767)  m_win = 32767;
        if (m_win < -32768) m_win = -32768;
    endtask

    task automatic do_pulse(input int hi, input int lo);
        model_rise();
        step = 1'b1;
        tick(hi);
        step = 1'b0;
        tick(lo);
        if (hi < c_MIN_HIGH) m_errp = 1;
    endtask

    task automatic close_window(input string tag);
        window_sync = 1'b1;
        tick(1);
        window_sync = 1'b0;
        check({tag, ".delta_valid"}, int'(delta_valid), 1);
        check({tag, ".delta_steps"}, int'(delta_steps), m_win);
        m_win = 0;
        tick(1);
        check({tag, ".delta_valid_drop"}, int'(delta_valid), 0);
    endtask

    task automatic do_err_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        m_errp = 0;
        m_errd = 0;
        tick(1);
    endtask

    task automatic do_zero();
        zero_pos = 1'b1;
        tick(1);
        zero_pos = 1'b0;
        m_pos = 0;
        tick(1);
    endtask

    initial begin
        int hi, lo;
        reset = 1'b1; step = 1'b0; dir = 1'b1;
        window_sync = 1'b0; zero_pos = 1'b0; err_clear = 1'b0;
        tick(3);
        check("rst.position", int'(position), 0);
        check("rst.delta_steps", int'(delta_steps), 0);
        check("rst.delta_valid", int'(delta_valid), 0);
        check("rst.err_pulse", int'(err_pulse), 0);
        check("rst.err_dir", int'(err_dir), 0);
        reset = 1'b0;
        m_gap = 0;
        tick(60);

        // Ten forward pulses, then close the window.
        for (int i = 0; i < 10; i++) do_pulse(100, 100);
        check_state("fwd10");
        close_window("win10");

        // Three reverse pulses from zero wrap below zero.
        do_zero();
        set_dir(1'b0);
        tick(60);
        for (int i = 0; i < 3; i++) do_pulse(100, 100);
        check_state("rev3");
        close_window("winm3");

        // 3199 -> 0 wrap going forward.
        do_zero();
        do_pulse(100, 100);
        check_state("to3199");
        set_dir(1'b1);
        tick(60);
        do_pulse(100, 100);
        check_state("wrap0");

        // Short step pulse: error flag, step still counted.
        do_pulse(20, 100);
        check_state("short");
        do_err_clear();
        check_state("short_clr");

        // Dir changed only 10 clocks before the step.
        set_dir(1'b0);
        tick(10);
        do_pulse(100, 100);
        check_state("late_dir");
        do_err_clear();
        check_state("late_dir_clr");

        // Fast stepping to position 500, then zero_pos coinciding with a rise.
        do_zero();
        set_dir(1'b1);
        tick(60);
        for (int i = 0; i < 500; i++) do_pulse(2, 2);
        tick(6);
        check_state("fast500");
        do_err_clear();
        close_window("win500");
        step = 1'b1;
        tick(2);
        zero_pos = 1'b1;       // coincides with the detected rise
        tick(1);
        zero_pos = 1'b0;
        m_pos = 0;
        m_win = 1;
        tick(60);
        step = 1'b0;
        tick(60);
        check_state("zero_rise");
        close_window("winzr");

        // Randomized pulse train against the model.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(2) == 0) begin
                set_dir(1'($urandom_range(1)));
                tick(60 + $urandom_range(20));
            end
            hi = ($urandom_range(4) == 0) ? 5 + $urandom_range(30) : 60 + $urandom_range(60);
            lo = 4 + $urandom_range(40);
            do_pulse(hi, lo);
            check_state($sformatf("rnd%0d", i));
            if ($urandom_range(3) == 0) close_window($sformatf("rndwin%0d", i));
            if (m_errp != 0) do_err_clear();
        end

        // Reset in the middle of a step pulse, released with step still high.
        tick(60);
        model_rise();
        step = 1'b1;
        tick(30);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_pos = 0; m_win = 0; m_errp = 0; m_errd = 0; m_gap = 0;
        tick(20);
        check_state("rst_mid_high");
        check("rst_mid.delta_steps", int'(delta_steps), 0);
        step = 1'b0;
        tick(60);
        check_state("rst_mid_low");
        do_pulse(80, 20);
        check_state("rst_mid_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_step_dir_decoder
`default_nettype wire
